// File: rtl/group_4_serializer.sv
// Four-word parallel-in / serial-out buffer with a valid/ready output handshake.
// A load in IDLE captures in1..in4; the words then leave in order, one per handshake.
module group_4_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];

  // State, index, done pulse and word buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Next-state logic; clr wins over both load and a pending handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      buf_d[i] = buf_q[i];
    end

    if (clr) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      for (int i = 0; i < 4; i++) begin
        buf_d[i] = {WIDTH{1'b0}};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            buf_d[0] = in1;
            buf_d[1] = in2;
            buf_d[2] = in3;
            buf_d[3] = in4;
            idx_d    = 2'd0;
            state_d  = SEND;
          end else begin
            state_d = IDLE;
          end
        end
        SEND: begin
          // load is deliberately not looked at here: the buffer is frozen mid-burst.
          if (out_ready) begin
            if (idx_q == 2'd3) begin
              state_d = IDLE;
              idx_d   = 2'd0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free after each edge.
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_idx   = (state_q == SEND) ? idx_q : 2'd0;
  assign out_data  = (state_q == SEND) ? buf_q[idx_q] : {WIDTH{1'b0}};
  assign done      = done_q;

endmodule

// File: tb/tb_group_4_serializer.sv
// Directed self-checking bench for group_4_serializer: bursts, back-pressure,
// ignored loads, back-to-back loads, clear priority and asynchronous reset mid-burst.
module tb_group_4_serializer;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        load;
  logic [31:0] in1, in2, in3, in4;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] words [4];
  logic [2:0]  pat_ready [7];
  int          exp_idx;

  group_4_serializer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (load),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy},      32'd0);
    check({tag, ".data"},  out_data,           32'd0);
    check({tag, ".idx"},   {30'd0, out_idx},   32'd0);
  endtask

  task automatic check_word(input string tag, input int k);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".busy"},  {31'd0, busy},      32'd1);
    check({tag, ".data"},  out_data,           words[k]);
    check({tag, ".idx"},   {30'd0, out_idx},   k[31:0]);
  endtask

  task automatic start_burst();
    in1 = words[0]; in2 = words[1]; in3 = words[2]; in4 = words[3];
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    words[3] = 32'h4444_4444;
    pat_ready[0] = 3'd1; pat_ready[1] = 3'd0; pat_ready[2] = 3'd0; pat_ready[3] = 3'd1;
    pat_ready[4] = 3'd1; pat_ready[5] = 3'd0; pat_ready[6] = 3'd1;

    rst = 1'b1; clr = 1'b0; load = 1'b0; out_ready = 1'b0;
    in1 = 32'd0; in2 = 32'd0; in3 = 32'd0; in4 = 32'd0;
    #2 rst = 1'b0;
    #1;
    check_idle("rst");
    check("rst.done", {31'd0, done}, 32'd0);
    step();
    check_idle("rst_edge");
    #1 rst = 1'b1;

    // Full burst with out_ready held high.
    out_ready = 1'b1;
    start_burst();
    for (int k = 0; k < 4; k++) begin
      check_word("burst", k);
      check("burst.done", {31'd0, done}, 32'd0);
      step();
    end
    check_idle("burst_end");
    check("burst.done_pulse", {31'd0, done}, 32'd1);
    step();
    check("burst.done_clear", {31'd0, done}, 32'd0);

    // Back-pressure pattern 1,0,0,1,1,0,1.
    start_burst();
    exp_idx = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = pat_ready[c][0];
      check_word("bp", exp_idx);
      check("bp.done", {31'd0, done}, 32'd0);
      step();
      if (pat_ready[c][0]) exp_idx++;
    end
    check("bp.handshakes", exp_idx[31:0], 32'd4);
    check_idle("bp_end");
    check("bp.done_pulse", {31'd0, done}, 32'd1);
    out_ready = 1'b1;
    step();

    // Load during SEND at idx=1 is ignored.
    start_burst();
    step();
    check_word("ign", 1);
    in1 = 32'hAAAA_AAAA; in2 = 32'hAAAA_AAAA; in3 = 32'hAAAA_AAAA; in4 = 32'hAAAA_AAAA;
    load = 1'b1;
    step();
    check_word("ign", 2);
    step();
    check_word("ign", 3);
    load = 1'b0;
    step();
    check("ign.done", {31'd0, done}, 32'd1);
    step();

    // Load on the done cycle gives a one-cycle gap then the new burst.
    start_burst();
    step(); step(); step(); step();
    check("b2b.done", {31'd0, done}, 32'd1);
    check("b2b.gap", {31'd0, out_valid}, 32'd0);
    in1 = 32'hDEAD_BEEF;
    load = 1'b1;
    step();
    load = 1'b0;
    check("b2b.valid", {31'd0, out_valid}, 32'd1);
    check("b2b.data", out_data, 32'hDEAD_BEEF);
    check("b2b.idx", {30'd0, out_idx}, 32'd0);
    step(); step(); step(); step();
    step();

    // clr together with load at idx=2.
    start_burst();
    step(); step();
    check_word("clr_pre", 2);
    clr = 1'b1; load = 1'b1;
    step();
    clr = 1'b0; load = 1'b0;
    check_idle("clr");
    check("clr.done", {31'd0, done}, 32'd0);
    step();
    check("clr.done_after", {31'd0, done}, 32'd0);
    check_idle("clr_after");

    // Asynchronous reset between edges at idx=2.
    start_burst();
    step(); step();
    check_word("arst_pre", 2);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_idle("arst");
    check("arst.done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    words[0] = 32'h5555_5555;
    start_burst();
    check_word("arst_reload", 0);
    step();
    check_word("arst_reload", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/group_4_serializer.md
GROUP_4_SERIALIZER -- requirements
Module: group_4_serializer

Interface
REQ-001 Parameter WIDTH, default 32, data word width of every data port and buffer register; SHALL be honoured by all data paths.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; SHALL take effect immediately when low, independent of clk.
REQ-004 clr  input  1  synchronous clear, active-high.
REQ-005 load  input  1  parallel-load request, sampled on the rising clk edge.
REQ-006 in1, in2, in3, in4  input  WIDTH each  the four words captured on an accepted load.
REQ-007 out_data  output  WIDTH  the word currently offered.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  downstream consumer accepts the offered word.
REQ-010 out_idx  output  2  index of the offered word: 0 = in1, 1 = in2, 2 = in3, 3 = in4.
REQ-011 busy  output  1  high while the block is in state SEND.
REQ-012 done  output  1  one-cycle pulse following the transfer of the 4th word.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SEND; all outputs SHALL be registered or decoded from registered state only.
REQ-014 In IDLE, load=1 at an edge SHALL capture in1..in4 into buf0..buf3, set idx=0 and enter SEND.
REQ-015 Latency: out_valid SHALL be 1 in the cycle immediately after the accepting edge, with out_data=buf0.
REQ-016 In SEND, out_valid SHALL be 1, out_data SHALL equal buf[idx], out_idx SHALL equal idx, and busy SHALL be 1.
REQ-017 A handshake SHALL occur on an edge where out_valid=1 and out_ready=1; exactly one word SHALL transfer per handshake.
REQ-018 When out_ready=0, out_data, out_idx and out_valid SHALL hold stable (no drop, no skip).
REQ-019 A handshake with idx<3 SHALL increment idx by 1.
REQ-020 A handshake with idx=3 SHALL return the FSM to IDLE, set idx=0 and pulse done=1 for exactly the following cycle.
REQ-021 In IDLE, out_valid=0, busy=0, out_idx=0 and out_data=0.
REQ-022 load while in SEND SHALL be ignored; the buffer SHALL stay unchanged.
REQ-023 load in the cycle where done=1 (the FSM is already in IDLE) SHALL be accepted, giving back-to-back bursts with a one-cycle out_valid gap.
REQ-024 clr=1 at an edge SHALL force IDLE, idx=0, buf0..buf3=0 and done=0, and SHALL take priority over load and over any handshake in the same cycle.
REQ-025 A full burst with out_ready held at 1 SHALL take exactly 4 cycles of out_valid=1.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, idx=0, buf0..buf3=0, out_data=0, out_valid=0, out_idx=0, busy=0 and done=0, including mid-burst.
REQ-027 After rst returns to 1, the first accepted load SHALL be honoured on the first rising edge.

Verification
REQ-028 Load in1..in4=0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=1 -> out_data sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles; out_idx 0, 1, 2, 3; done=1 on the 5th cycle.
REQ-029 Same load with out_ready toggling 1,0,0,1,1,0,1 -> each word held while out_ready=0, no word lost or duplicated, done after the 4th handshake.
REQ-030 Assert load=1 with new data (0xAAAAAAAA on all inputs) during SEND at idx=1 -> remaining words still 0x22222222, 0x33333333, 0x44444444.
REQ-031 Assert load on the done cycle with in1=0xDEADBEEF -> next cycle out_valid=1 and out_data=0xDEADBEEF.
REQ-032 Assert clr=1 and load=1 together at idx=2 -> IDLE, out_valid=0, busy=0, done never pulses, buffer reads 0.
REQ-033 Drive rst=0 between clock edges during SEND at idx=2 -> out_valid, busy and out_data go to 0 immediately; after release, a fresh load starts at out_idx=0.
